// File: rtl/frame_check_pkg.sv
// frame_check_pkg: PRBS7 defaults, frame checker FSM state encodings and popcount helper
package frame_check_pkg;
  localparam logic [6:0] PRBS7_POLY = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] OVERRUN = 2'd2;
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/prbs_frame_checker_prbs_gen.sv
// prbs_gen: parallel LFSR producing DATA_W PRBS bits per step (MSB generated first); ports Clock, Reset (async low), Load (reseed), Adv (step DATA_W bits), Bits (current beat)
module prbs_gen
  import frame_check_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY = LFSR_W'(PRBS7_POLY),
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(PRBS7_SEED)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic              Adv,
  output logic [DATA_W-1:0] Bits
);
  logic [LFSR_W-1:0] state, nxt;
  always_comb begin
    nxt = state;
    Bits = '0;
    for (int i = 0; i < DATA_W; i++) begin
      Bits[DATA_W-1-i] = ^(nxt & POLY);
      nxt = {nxt[LFSR_W-2:0], Bits[DATA_W-1-i]};
    end
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= SEED;
    else if (Load) state <= SEED;
    else if (Adv) state <= nxt;
endmodule

// File: rtl/prbs_frame_checker.sv
// prbs_frame_checker: compares received frame beats against a per-frame reseeded PRBS; ports Clock, Reset (async low), DataIn/DataInEn (beats), Clear (stat clear), DataWrong (beat mismatch), FrameDone/FrameErr/FrameOvf/FrameBitErrs (frame result), FrameCnt/ErrFrameCnt (stats, only with FRAME_CHECK_STATS_EN)
module prbs_frame_checker
  import frame_check_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY = LFSR_W'(PRBS7_POLY),
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(PRBS7_SEED),
  parameter int MAX_BEATS = 64,
  parameter int ERR_CNT_W = 8,
  parameter int STAT_W = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DATA_W-1:0]    DataIn,
  input  logic                 DataInEn,
  input  logic                 Clear,
  output logic                 DataWrong,
  output logic                 FrameDone,
  output logic                 FrameErr,
  output logic                 FrameOvf,
  output logic [ERR_CNT_W-1:0] FrameBitErrs,
  output logic [STAT_W-1:0]    FrameCnt,
  output logic [STAT_W-1:0]    ErrFrameCnt
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int unsigned ACC_MAX = (1 << ERR_CNT_W) - 1;
  logic [1:0] state;
  logic [BW-1:0] beats, beats_nxt;
  logic [DATA_W-1:0] exp0, data1, exp1;
  logic en1, cmp1, close1, ovf, start;
  logic [ERR_CNT_W-1:0] acc;
  int unsigned sum;
  prbs_gen #(.DATA_W(DATA_W), .LFSR_W(LFSR_W), .POLY(POLY), .SEED(SEED)) u_gen (
    .Clock(Clock), .Reset(Reset), .Load(!DataInEn), .Adv(DataInEn), .Bits(exp0)
  );
  assign start = DataInEn && state == IDLE;
  assign beats_nxt = state == IDLE ? BW'(1) : beats + BW'(1);
  assign sum = 32'(acc) + popcount(64'(data1 ^ exp1));
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      beats <= '0;
    end else if (!DataInEn) begin
      state <= IDLE;
      beats <= '0;
    end else if (state != OVERRUN) begin
      beats <= beats_nxt;
      state <= beats_nxt >= BW'(MAX_BEATS) ? OVERRUN : FRAME;
    end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      data1 <= '0;
      exp1 <= '0;
      en1 <= 1'b0;
      cmp1 <= 1'b0;
      close1 <= 1'b0;
      DataWrong <= 1'b0;
    end else begin
      data1 <= DataIn;
      exp1 <= exp0;
      en1 <= DataInEn;
      cmp1 <= state != OVERRUN;
      close1 <= !DataInEn && state != IDLE;
      DataWrong <= en1 && cmp1 && data1 != exp1;
    end
  // A new frame may start on the same edge that publishes the previous close;
  // the close reads the pre-clear accumulator values.
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= start ? '0 : (en1 && cmp1) ? (sum > ACC_MAX ? '1 : ERR_CNT_W'(sum)) : acc;
      ovf <= start ? 1'b0 : ovf | (DataInEn && state == OVERRUN);
    end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      FrameDone <= 1'b0;
      FrameErr <= 1'b0;
      FrameOvf <= 1'b0;
      FrameBitErrs <= '0;
    end else begin
      FrameDone <= close1;
      FrameErr <= close1 && acc != '0;
      FrameOvf <= close1 && ovf;
      FrameBitErrs <= close1 ? acc : '0;
    end
`ifdef FRAME_CHECK_STATS_EN
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      FrameCnt <= '0;
      ErrFrameCnt <= '0;
    end else if (Clear) begin
      FrameCnt <= '0;
      ErrFrameCnt <= '0;
    end else begin
      if (FrameDone && FrameCnt != '1) FrameCnt <= FrameCnt + STAT_W'(1);
      if (FrameDone && FrameErr && ErrFrameCnt != '1) ErrFrameCnt <= ErrFrameCnt + STAT_W'(1);
    end
`else
  logic unused_clear;
  assign unused_clear = Clear;
  assign FrameCnt = '0;
  assign ErrFrameCnt = '0;
`endif
endmodule

// File: tb/tb_prbs_frame_checker.sv
// tb_prbs_frame_checker: randomized and directed check of prbs_frame_checker against a frame-level reference model
module tb_prbs_frame_checker;
  localparam int MB = 4;
  localparam int N = 8192;
`ifdef FRAME_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic Clock = 1'b0, Reset = 1'b0, DataInEn = 1'b0, Clear = 1'b0;
  logic [7:0] DataIn = '0;
  logic DataWrong, FrameDone, FrameErr, FrameOvf;
  logic [3:0] FrameBitErrs;
  logic [15:0] FrameCnt, ErrFrameCnt;
  prbs_frame_checker #(
    .DATA_W(8), .LFSR_W(7), .POLY(7'h60), .SEED(7'h7F), .MAX_BEATS(MB), .ERR_CNT_W(4), .STAT_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataInEn(DataInEn), .Clear(Clear),
    .DataWrong(DataWrong), .FrameDone(FrameDone), .FrameErr(FrameErr), .FrameOvf(FrameOvf),
    .FrameBitErrs(FrameBitErrs), .FrameCnt(FrameCnt), .ErrFrameCnt(ErrFrameCnt)
  );
  always #5 Clock = ~Clock;
  int total = 0, bad = 0, edge_n = 0;
  logic [7:0] prbs_beat [MB];
  bit exp_dw [N], exp_fd [N], exp_fe [N], exp_fo [N];
  int exp_be [N];
  bit in_frame = 0, f_ovf = 0;
  int f_idx = 0, f_errs = 0, m_fc = 0, m_efc = 0;
  logic [7:0] fq [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (edge %0d)", tag, got, want, edge_n);
    end
  endtask
  task automatic clear_model();
    in_frame = 0;
    m_fc = 0;
    m_efc = 0;
    for (int i = 0; i < N; i++) begin
      exp_dw[i] = 0;
      exp_fd[i] = 0;
      exp_fe[i] = 0;
      exp_fo[i] = 0;
      exp_be[i] = 0;
    end
  endtask
  task automatic cycle(input bit en, input logic [7:0] d, input bit clr);
    DataInEn = en;
    DataIn = d;
    Clear = clr;
    @(posedge Clock);
    edge_n++;
    if (clr) begin
      m_fc = 0;
      m_efc = 0;
    end else if (exp_fd[edge_n-1]) begin
      if (m_fc < 65535) m_fc++;
      if (exp_fe[edge_n-1] && m_efc < 65535) m_efc++;
    end
    if (en) begin
      if (!in_frame) begin
        in_frame = 1;
        f_idx = 0;
        f_errs = 0;
        f_ovf = 0;
      end
      if (f_idx < MB) begin
        exp_dw[edge_n+1] = d != prbs_beat[f_idx];
        f_errs = f_errs + $countones(d ^ prbs_beat[f_idx]);
        if (f_errs > 15) f_errs = 15;
      end else f_ovf = 1;
      f_idx++;
    end else if (in_frame) begin
      in_frame = 0;
      exp_fd[edge_n+1] = 1;
      exp_fe[edge_n+1] = f_errs != 0;
      exp_fo[edge_n+1] = f_ovf;
      exp_be[edge_n+1] = f_errs;
    end
    @(negedge Clock);
    check("data_wrong", DataWrong, exp_dw[edge_n]);
    check("frame_done", FrameDone, exp_fd[edge_n]);
    check("frame_err", FrameErr, exp_fe[edge_n]);
    check("frame_ovf", FrameOvf, exp_fo[edge_n]);
    check("frame_bit_errs", FrameBitErrs, exp_be[edge_n]);
    check("frame_cnt", FrameCnt, STATS ? m_fc : 0);
    check("err_frame_cnt", ErrFrameCnt, STATS ? m_efc : 0);
  endtask
  task automatic do_reset(input int n);
    #2 Reset = 1'b0;
    DataInEn = 1'b0;
    Clear = 1'b0;
    #1;
    check("rst_data_wrong", DataWrong, 0);
    check("rst_frame_done", FrameDone, 0);
    check("rst_frame_err", FrameErr, 0);
    check("rst_frame_ovf", FrameOvf, 0);
    check("rst_bit_errs", FrameBitErrs, 0);
    check("rst_frame_cnt", FrameCnt, 0);
    check("rst_err_frame_cnt", ErrFrameCnt, 0);
    clear_model();
    repeat (n) begin
      @(posedge Clock);
      edge_n++;
    end
    @(negedge Clock);
    check("rst_hold_done", FrameDone, 0);
    Reset = 1'b1;
  endtask
  task automatic send(input int gap);
    foreach (fq[i]) cycle(1'b1, fq[i], 1'b0);
    repeat (gap) cycle(1'b0, 8'h00, 1'b0);
  endtask
  function automatic logic [7:0] good(input int i);
    return i < MB ? prbs_beat[i] : 8'($urandom);
  endfunction
  initial begin
    logic [6:0] s;
    logic fb;
    s = 7'h7F;
    for (int k = 0; k < MB; k++)
      for (int b = 0; b < 8; b++) begin
        fb = ^(s & 7'h60);
        prbs_beat[k][7-b] = fb;
        s = {s[5:0], fb};
      end
    do_reset(3);
    fq = {good(0), good(1), good(2)};
    send(4);
    fq = {good(0), good(1) ^ 8'h05, good(2)};
    send(4);
    fq = {good(0), good(1), good(2)};
    send(1);
    send(4);
    fq = {good(0), good(1), good(2), good(3), 8'hFF, 8'hFF};
    send(4);
    fq = {~good(0), ~good(1), ~good(2), ~good(3)};
    send(4);
    cycle(1'b1, good(0), 1'b0);
    cycle(1'b1, good(1), 1'b0);
    do_reset(2);
    fq = {good(0), good(1), good(2)};
    send(4);
    fq = {good(0), good(1) ^ 8'h80, good(2)};
    foreach (fq[i]) cycle(1'b1, fq[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("clear_wins_cnt", FrameCnt, 0);
    check("clear_wins_err_cnt", ErrFrameCnt, 0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(1, 6);
      fq = {};
      for (int i = 0; i < len; i++)
        fq.push_back($urandom_range(0, 3) == 0 ? good(i) ^ 8'($urandom) : good(i));
      if (f == 100) begin
        cycle(1'b1, fq[0], 1'b0);
        do_reset(1);
      end
      foreach (fq[i]) cycle(1'b1, fq[i], 1'b0);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 8'h00, $urandom_range(0, 15) == 0);
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
